// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, constants and helpers for the sequential divider
package div_pkg;

    localparam int DEF_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Width that can hold every value 0..n, so a step count of n never wraps.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/u_seqdiv_if.sv
// rtl/u_seqdiv_if.sv - operand/result handshake bundle for the sequential divider
interface u_seqdiv_if #(
    parameter int N = div_pkg::DEF_N
) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, r, dz
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, r, dz
    );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division step: shift, trial subtract, select
module div_step
    import div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] r_i,
    input  logic         bit_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] r_o,
    output logic         q_o
);

    logic [N:0] shifted;
    logic [N:0] trial;
    logic [N:0] sel;
    logic       unused_sel_msb;

    // The shifted remainder can reach 2^(N+1)-1, so the trial subtract is N+1
    // bits wide; divisors with the top bit set are then compared correctly.
    always_comb begin
        shifted = {r_i, bit_i};
        trial   = shifted - {1'b0, d_i};
        q_o     = (shifted >= {1'b0, d_i});
        sel     = q_o ? trial : shifted;
    end

    // Whichever value is kept is below 2^N (either < divisor or < shifted with
    // a cleared top bit after restore), so the top bit is always zero.
    assign r_o            = sel[N-1:0];
    assign unused_sel_msb = sel[N];

endmodule

// File: rtl/u_seqdiv.sv
// rtl/u_seqdiv.sv - sequential restoring divider, one quotient bit per clock (SEQDIV_TRUNC_EN enables low-bit truncation)
module u_seqdiv
    import div_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int TRUNC_K = 0
) (
    input  logic        clk,
    input  logic        rst,
    u_seqdiv_if.slave   div_if
);

`ifdef SEQDIV_TRUNC_EN
    localparam int STEPS = N - TRUNC_K;
`else
    localparam int STEPS = N;
`endif
    localparam int CW = cnt_width(N);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("u_seqdiv: N must be in 2..32");
    end
    if (TRUNC_K < 0 || TRUNC_K > N - 1) begin : g_bad_k
        $error("u_seqdiv: TRUNC_K must be in 0..N-1");
    end

    div_state_e   state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] r_q, r_d;
    logic [N-1:0] d_q, d_d;
    logic         dz_q, dz_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic         accept;
    logic         last_step;
    logic [N-1:0] step_r;
    logic         step_qbit;

    assign accept    = div_if.in_valid && (state_q == IDLE);
    assign last_step = (cnt_q == CW'(STEPS - 1));

    div_step #(.N(N)) u_step (
        .r_i   (r_q),
        .bit_i (q_q[N-1]),
        .d_i   (d_q),
        .r_o   (step_r),
        .q_o   (step_qbit)
    );

    // State register; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept -> STEPS run cycles -> hold result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (div_if.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and result presentation.
    always_comb begin
        div_if.in_ready  = (state_q == IDLE);
        div_if.out_valid = (state_q == DONE);
`ifdef SEQDIV_TRUNC_EN
        // Computed bits sit in the low STEPS positions; move them to the top.
        div_if.q = q_q << TRUNC_K;
`else
        div_if.q = q_q;
`endif
        div_if.r  = r_q;
        div_if.dz = dz_q;
    end

    // Datapath next state: capture on accept, one restoring step per RUN cycle.
    always_comb begin
        q_d   = q_q;
        r_d   = r_q;
        d_d   = d_q;
        dz_d  = dz_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    q_d   = div_if.a;
                    d_d   = div_if.b;
                    r_d   = '0;
                    dz_d  = (div_if.b == '0);
                    cnt_d = '0;
                end
            end
            RUN: begin
                q_d   = {q_q[N-2:0], step_qbit};
                r_d   = step_r;
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            dz_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            r_q   <= r_d;
            d_q   <= d_d;
            dz_q  <= dz_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/u_seqdiv.md
Name: u_seqdiv

Overview:
- Sequential unsigned restoring divider that produces one quotient bit per clock.
- It is the inverse-direction counterpart to the array/truncated multipliers in the arithmetic generator library.
- Accepts dividend/divisor through a valid/ready handshake and returns quotient, remainder and a divide-by-zero flag through a second valid/ready handshake.
- Intended as the reference sequential divider for approximate-arithmetic accuracy and area comparisons.

Parameters:
- N, 8, operand width in bits; legal range 2..32.
- TRUNC_K, 0, number of low quotient bits skipped. Only meaningful with SEQDIV_TRUNC_EN; legal range 0..N-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  dividend/divisor presented.
- in_ready  output  1  block can accept operands.
- a  input  N  unsigned dividend.
- b  input  N  unsigned divisor.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- q  output  N  quotient.
- r  output  N  remainder.
- dz  output  1  divisor was zero.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0, q=0, r=0, dz=0.
  - Step counter 0.
- Reset mid-operation aborts immediately to the reset values. No partial result is ever emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&in_ready, latch a into the quotient/shift register, b into the divisor register, clear the partial remainder R, set dz=(b==0), clear the counter, go to RUN.
  - Inputs are sampled only on that edge; later changes to a/b have no effect.
- RUN:
  - in_ready=0.
  - Each edge performs one restoring step: shift {R,Q} left by 1; T=R-divisor computed at N+1 bits.
  - If T is non-negative: R=T and the Q lsb is 1. Otherwise R is unchanged and the Q lsb is 0.
  - After step STEPS (STEPS=N exact), go to DONE.
- DONE:
  - out_valid=1.
  - q, r, dz are held stable while out_ready=0 (unlimited backpressure).
  - The edge with out_valid&out_ready returns to IDLE. in_ready rises on that edge, not before, so there are no overlapping transactions.
- Latency:
  - out_valid rises STEPS clock edges after the accept edge (N=8 exact: 8).
  - Minimum throughput is one division per STEPS+2 cycles.
- Divide by zero: no special path. The natural restoring result is q=all ones and r=a, with dz=1 and the same latency.
- Width rules:
  - The subtract is N+1 bits wide so divisor values >= 2^(N-1) are handled correctly.
  - Invariant for exact mode with b!=0: a == q*b + r and r < b.
- The counter is ceil(log2(N+1)) bits and never wraps; its terminal compare is exact.
- out_ready asserted while out_valid=0 is ignored. in_valid in RUN/DONE is ignored; the operands are not captured.

Optional Feature:
- Macro: SEQDIV_TRUNC_EN.
- Defined:
  - STEPS=N-TRUNC_K. Only the N-TRUNC_K most significant quotient bits are computed.
  - After those steps, q = computed bits shifted left by TRUNC_K with the low TRUNC_K bits forced to 0.
  - r = partial remainder R after the last performed step, i.e. floor(a/2^TRUNC_K) mod b.
  - Latency is N-TRUNC_K.
- Undefined: STEPS=N, TRUNC_K is ignored, and behaviour is exact.
- With TRUNC_K=0 the macro-enabled build is cycle- and bit-identical to the exact build.

Decomposition:
- Shared package div_pkg:
  - State enum (IDLE, RUN, DONE).
  - Helper function for counter width.
  - Constant for default N.
- One natural sub-module: div_step. Combinational; inputs R, shifted-in bit, divisor; outputs the next R and the quotient bit. It contains the N+1-bit subtract and select.
- The top level owns the FSM, counter, registers and handshakes.

Test Plan:
- N=8, a=200, b=7, out_ready=1 -> out_valid exactly 8 edges after accept; q=28, r=4, dz=0; in_ready back to 1 one edge later.
- a=255, b=1 -> q=255, r=0. Then a=3, b=10 -> q=0, r=3. Then a=255, b=255 -> q=1, r=0. Then a=254, b=128 -> q=1, r=126 (exercises the N+1-bit subtract).
- a=5, b=0 -> q=255, r=5, dz=1, latency 8.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> q/r/dz stable and in_ready=0 throughout. in_valid pulsed with other operands during the stall is not captured. Release -> single transfer, then IDLE.
- Reset asserted asynchronously at step 4 of a=200, b=7 -> outputs zero immediately, state IDLE, no out_valid; the next transaction a=100, b=9 gives q=11, r=1.
- SEQDIV_TRUNC_EN, TRUNC_K=4, a=200, b=7 -> latency 4, q=16, r=5. With TRUNC_K=0, results match exact mode over a 10k random sweep checked against a==q*b+r.
